ysyx_issue_ctrl: RTL and testbench

YSYX_ISSUE_CTRL -- requirements
Module: ysyx_issue_ctrl

---
 rtl/ysyx_issue_ctrl_pkg.sv | 15 +
 rtl/ysyx_issue_ctrl_scoreboard.sv | 43 ++++
 rtl/ysyx_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_ysyx_issue_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_issue_ctrl_pkg.sv
// Shared definitions for the issue controller: register-file size and the
// issue FSM state encoding.
package ysyx_issue_ctrl_pkg;

    localparam int unsigned NREG = 16;
    localparam int unsigned REGW = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SOLO  = 2'd2,
        BAD   = 2'd3
    } issue_state_e;

endpackage

// File: rtl/ysyx_issue_ctrl_scoreboard.sv
// Register busy scoreboard: one pending-write bit per architectural register.
// Flush beats set, set beats clear, and x0 never reads busy.
module ysyx_scoreboard
    import ysyx_issue_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            set_i,
    input  logic [REGW-1:0] set_rd_i,
    input  logic            clr_i,
    input  logic [REGW-1:0] clr_rd_i,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ysyx_issue_ctrl.sv
// Issue controller: RAW hazard check against the scoreboard, in-flight limit,
// and serialization of system/CSR instructions via a RUN/DRAIN/SOLO FSM.
module ysyx_issue_ctrl
    import ysyx_issue_ctrl_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            idu_valid,
    output logic            idu_ready,
    input  logic [REGW-1:0] rs1,
    input  logic [REGW-1:0] rs2,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic [REGW-1:0] rd,
    input  logic            wen,
    input  logic            serial,
    output logic            exu_valid,
    input  logic            exu_ready,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_rd,
    input  logic            commit,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [2:0]      inflight,
    output logic [1:0]      state,
    output logic            err
);

    localparam logic [2:0] MAX_Q = 3'(MAX_INFLIGHT);

    issue_state_e    state_q, state_d;
    logic [2:0]      inflight_q, inflight_d;
    logic            err_q, err_d;
    logic [NREG-1:0] busy_w;
    logic            hazard, permit, can_issue, issue;

    assign hazard = (use_rs1 & busy_w[rs1]) | (use_rs2 & busy_w[rs2]);

    always_comb begin
        permit = 1'b0;
        case (state_q)
            RUN:     permit = !serial || (inflight_q == '0);
            DRAIN:   permit = serial && (inflight_q == '0);
            default: permit = 1'b0;
        endcase
    end

    // reset gates the handshake directly so nothing leaks out while held
    assign can_issue = reset & !flush & !hazard & (inflight_q < MAX_Q) & permit;
    assign exu_valid = idu_valid & can_issue;
    assign idu_ready = exu_ready & can_issue;
    assign issue     = exu_valid & exu_ready;

    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (flush) begin
            inflight_d = '0;
        end else if (issue && !commit) begin
            inflight_d = inflight_q + 3'd1;
        end else if (commit && !issue) begin
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (issue && serial) begin
                        state_d = SOLO;
                    end else if (idu_valid && serial && (inflight_q != '0)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        state_d = SOLO;
                    end
                end
                SOLO: begin
                    if (inflight_d == '0) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    ysyx_scoreboard u_scoreboard (
        .clk_i    (clock),
        .rst_ni   (reset),
        .flush_i  (flush),
        .set_i    (issue & wen & (rd != '0)),
        .set_rd_i (rd),
        .clr_i    (wb_valid),
        .clr_rd_i (wb_rd),
        .busy_o   (busy_w)
    );

    assign busy     = busy_w;
    assign inflight = inflight_q;
    assign state    = state_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ysyx_issue_ctrl.sv
// Self-checking bench for ysyx_issue_ctrl: directed vector tables, hand-written
// multi-cycle sequences, and random traffic against a behavioural model.
module tb_ysyx_issue_ctrl;

    localparam int MAXI = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        idu_valid, idu_ready;
    logic [3:0]  rs1, rs2, rd, wb_rd;
    logic        use_rs1, use_rs2, wen, serial;
    logic        exu_valid, exu_ready, wb_valid, commit, flush;
    logic [15:0] busy;
    logic [2:0]  inflight;
    logic [1:0]  state;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    ysyx_issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
        .clock     (clock),
        .reset     (reset),
        .idu_valid (idu_valid),
        .idu_ready (idu_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .use_rs1   (use_rs1),
        .use_rs2   (use_rs2),
        .rd        (rd),
        .wen       (wen),
        .serial    (serial),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .commit    (commit),
        .flush     (flush),
        .busy      (busy),
        .inflight  (inflight),
        .state     (state),
        .err       (err)
    );

    // ---------------- behavioural reference model ----------------
    int m_cnt;
    bit m_busy[16];
    bit m_wait;   // a serial instruction is waiting for older work to retire
    bit m_solo;   // a serial instruction is executing alone
    bit m_err;

    function automatic void model_reset(input bit clear_err);
        m_cnt  = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wait = 1'b0;
        m_solo = 1'b0;
        if (clear_err) m_err = 1'b0;
    endfunction

    function automatic bit m_ok();
        bit hz, allowed;
        hz = (use_rs1 && m_busy[rs1]) || (use_rs2 && m_busy[rs2]);
        if (m_solo)      allowed = 1'b0;
        else if (serial) allowed = (m_cnt == 0);
        else             allowed = !m_wait;
        return reset && !flush && !hz && (m_cnt < MAXI) && allowed;
    endfunction

    function automatic logic [15:0] m_busy_vec();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int m_state();
        return m_solo ? 2 : (m_wait ? 1 : 0);
    endfunction

    function automatic void model_update();
        bit iss;
        int nc;
        iss = m_ok() && idu_valid && exu_ready;
        if (flush) begin
            model_reset(1'b0);
        end else begin
            nc = m_cnt + int'(iss) - int'(commit);
            if (nc < 0) begin
                nc    = 0;
                m_err = 1'b1;
            end
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (iss && wen && rd != 0) m_busy[rd] = 1'b1;
            if (m_solo) begin
                if (nc == 0) m_solo = 1'b0;
            end else if (iss && serial) begin
                m_solo = 1'b1;
                m_wait = 1'b0;
            end else if (idu_valid && serial && m_cnt != 0) begin
                m_wait = 1'b1;
            end
            m_cnt = nc;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_check();
        chk("exu_valid", 32'(exu_valid), 32'(m_ok() && idu_valid));
        chk("idu_ready", 32'(idu_ready), 32'(m_ok() && exu_ready));
        chk("busy",      32'(busy),      32'(m_busy_vec()));
        chk("inflight",  32'(inflight),  32'(m_cnt));
        chk("state",     32'(state),     32'(m_state()));
        chk("err",       32'(err),       32'(m_err));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_update();
        @(negedge clock);
    endtask

    task automatic drv(input int idv, input int r1, input int u1, input int d, input int w,
                       input int ser, input int exr, input int wbv, input int wbr,
                       input int cm, input int fl);
        idu_valid = (idv != 0); rs1 = 4'(r1); use_rs1 = (u1 != 0);
        rs2 = '0; use_rs2 = 1'b0;
        rd = 4'(d); wen = (w != 0); serial = (ser != 0); exu_ready = (exr != 0);
        wb_valid = (wbv != 0); wb_rd = 4'(wbr); commit = (cm != 0); flush = (fl != 0);
    endtask

    task automatic step_chk(input string nm, input int ev, input int st, input int inf, input int bz);
        #1;
        model_check();
        chk({nm, ".exu_valid"}, 32'(exu_valid), 32'(ev));
        chk({nm, ".state"},     32'(state),     32'(st));
        chk({nm, ".inflight"},  32'(inflight),  32'(inf));
        chk({nm, ".busy"},      32'(busy),      32'(bz));
        tick();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        idv;
        logic [3:0]  rs1;
        logic        u1;
        logic [3:0]  rd;
        logic        wen, ser, exr, wbv;
        logic [3:0]  wbrd;
        logic        cm;
        logic        e_ev, e_ir;
        logic [15:0] e_busy;
        logic [2:0]  e_inf;
        logic [1:0]  e_st;
        logic        e_err;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input int idv, input int r1, input int u1, input int d,
                                input int w, input int ser, input int exr, input int wbv,
                                input int wbr, input int cm, input int ev, input int ir,
                                input int bz, input int inf, input int st, input int er);
        vec_t v;
        v.idv = (idv != 0); v.rs1 = 4'(r1); v.u1 = (u1 != 0); v.rd = 4'(d);
        v.wen = (w != 0); v.ser = (ser != 0); v.exr = (exr != 0); v.wbv = (wbv != 0);
        v.wbrd = 4'(wbr); v.cm = (cm != 0); v.e_ev = (ev != 0); v.e_ir = (ir != 0);
        v.e_busy = 16'(bz); v.e_inf = 3'(inf); v.e_st = 2'(st); v.e_err = (er != 0);
        return v;
    endfunction

    initial begin
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset(1'b1);

        //           idv rs1 u1 rd wen ser exr wbv wbrd cm  ev ir busy    inf st err
        // RAW stall on x5, released the cycle after its writeback
        tab.push_back(mk(1, 0, 0,  5, 1, 0, 1, 0, 0, 0,  1, 1, 'h0000, 0, 0, 0));
        tab.push_back(mk(1, 5, 1,  6, 1, 0, 1, 0, 0, 0,  0, 0, 'h0020, 1, 0, 0));
        tab.push_back(mk(1, 5, 1,  6, 1, 0, 1, 1, 5, 0,  0, 0, 'h0020, 1, 0, 0));
        tab.push_back(mk(1, 5, 1,  6, 1, 0, 1, 0, 0, 0,  1, 1, 'h0000, 1, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 6, 1,  0, 0, 'h0040, 2, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 'h0000, 1, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 'h0000, 0, 0, 0));
        // capacity: four issue, fifth waits for a commit
        tab.push_back(mk(1, 0, 0,  8, 1, 0, 1, 0, 0, 0,  1, 1, 'h0000, 0, 0, 0));
        tab.push_back(mk(1, 0, 0,  9, 1, 0, 1, 0, 0, 0,  1, 1, 'h0100, 1, 0, 0));
        tab.push_back(mk(1, 0, 0, 10, 1, 0, 1, 0, 0, 0,  1, 1, 'h0300, 2, 0, 0));
        tab.push_back(mk(1, 0, 0, 11, 1, 0, 1, 0, 0, 0,  1, 1, 'h0700, 3, 0, 0));
        tab.push_back(mk(1, 0, 0, 12, 1, 0, 1, 0, 0, 0,  0, 0, 'h0F00, 4, 0, 0));
        tab.push_back(mk(1, 0, 0, 12, 1, 0, 1, 0, 0, 1,  0, 0, 'h0F00, 4, 0, 0));
        tab.push_back(mk(1, 0, 0, 12, 1, 0, 1, 0, 0, 0,  1, 1, 'h0F00, 3, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 8, 1,  0, 0, 'h1F00, 4, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 9, 1,  0, 0, 'h1E00, 3, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 10, 1, 0, 0, 'h1C00, 2, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 11, 1, 0, 0, 'h1800, 1, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 12, 0, 0, 0, 'h1000, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 'h0000, 0, 0, 0));
        // set/clear collision on x7, then commit underflow, then x0 never busy
        tab.push_back(mk(1, 0, 0,  7, 1, 0, 1, 1, 7, 0,  1, 1, 'h0000, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 'h0080, 1, 0, 0));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 7, 1,  0, 0, 'h0080, 0, 0, 0));
        tab.push_back(mk(1, 0, 0,  0, 1, 0, 1, 0, 0, 0,  1, 1, 'h0000, 0, 0, 1));
        tab.push_back(mk(1, 0, 1,  3, 0, 0, 1, 0, 0, 0,  1, 1, 'h0000, 1, 0, 1));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 'h0000, 2, 0, 1));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 'h0000, 1, 0, 1));
        tab.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 'h0000, 0, 0, 1));

        // reset values
        @(negedge clock);
        #1;
        model_check();
        @(negedge clock);
        reset = 1'b1;

        foreach (tab[i]) begin
            drv(int'(tab[i].idv), int'(tab[i].rs1), int'(tab[i].u1), int'(tab[i].rd),
                int'(tab[i].wen), int'(tab[i].ser), int'(tab[i].exr), int'(tab[i].wbv),
                int'(tab[i].wbrd), int'(tab[i].cm), 0);
            #1;
            model_check();
            chk($sformatf("tab%0d.exu_valid", i), 32'(exu_valid), 32'(tab[i].e_ev));
            chk($sformatf("tab%0d.idu_ready", i), 32'(idu_ready), 32'(tab[i].e_ir));
            chk($sformatf("tab%0d.busy", i),      32'(busy),      32'(tab[i].e_busy));
            chk($sformatf("tab%0d.inflight", i),  32'(inflight),  32'(tab[i].e_inf));
            chk($sformatf("tab%0d.state", i),     32'(state),     32'(tab[i].e_st));
            chk($sformatf("tab%0d.err", i),       32'(err),       32'(tab[i].e_err));
            tick();
        end

        // reset mid-operation behaves like a flush and clears the sticky error
        drv(1, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0); step_chk("rst_a", 1, 0, 0, 'h0000);
        drv(1, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0); step_chk("rst_b", 1, 0, 1, 'h0010);
        reset = 1'b0;
        model_reset(1'b1);
        #1;
        model_check();
        chk("rst_hold.exu_valid", 32'(exu_valid), 32'(0));
        chk("rst_hold.idu_ready", 32'(idu_ready), 32'(0));
        chk("rst_hold.inflight",  32'(inflight),  32'(0));
        chk("rst_hold.err",       32'(err),       32'(0));
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        drv(1, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0); step_chk("rst_c", 1, 0, 0, 'h0000);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step_chk("rst_d", 0, 0, 1, 'h0000);

        // serialization: drain two older instructions, run alone, then resume
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step_chk("ser_a", 1, 0, 0, 'h0000);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step_chk("ser_b", 1, 0, 1, 'h0000);
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step_chk("ser_c", 0, 0, 2, 'h0000);
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0); step_chk("ser_d", 0, 1, 2, 'h0000);
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0); step_chk("ser_e", 0, 1, 1, 'h0000);
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step_chk("ser_f", 1, 1, 0, 'h0000);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step_chk("ser_g", 0, 2, 1, 'h0000);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); step_chk("ser_h", 0, 2, 1, 'h0000);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); step_chk("ser_i", 1, 0, 0, 'h0000);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step_chk("ser_j", 0, 0, 1, 'h0000);

        // flush in SOLO with busy=0x0024; commit and writeback in that cycle are dropped
        drv(1, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0); step_chk("fl_a", 1, 0, 0, 'h0000);
        drv(1, 0, 0, 5, 1, 1, 1, 0, 0, 1, 0); step_chk("fl_b", 0, 0, 1, 'h0004);
        drv(1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0); step_chk("fl_c", 1, 1, 0, 'h0004);
        drv(1, 0, 0, 9, 1, 0, 1, 1, 2, 1, 1);
        #1;
        chk("fl_d.idu_ready", 32'(idu_ready), 32'(0));
        step_chk("fl_d", 0, 2, 1, 'h0024);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step_chk("fl_e", 0, 0, 0, 'h0000);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idu_valid = ($urandom_range(0, 3) != 0);
            rs1       = 4'($urandom_range(0, 15));
            rs2       = 4'($urandom_range(0, 15));
            use_rs1   = ($urandom_range(0, 1) != 0);
            use_rs2   = ($urandom_range(0, 2) == 0);
            rd        = 4'($urandom_range(0, 15));
            wen       = ($urandom_range(0, 3) != 0);
            serial    = ($urandom_range(0, 7) == 0);
            exu_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = 4'($urandom_range(0, 15));
            commit    = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            model_check();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
